// File: rtl/instr_fetch_prefetch.sv
// Instruction fetch stage: issues sequential word fetches, buffers in-order responses with their
// PC in a prefetch FIFO, and presents {pc, instr} to the core; a redirect flushes the stage.
module instr_fetch_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];

  logic [CW:0] inflight;
  logic        accept, rsp_ok, push, pop;

  assign inflight      = {1'b0, count_q} + {1'b0, out_q};
  assign mem_req_valid = !rst && !redirect_valid && (inflight < DEPTH_W);
  assign mem_req_addr  = rst ? RESET_PC : fetch_pc_q;
  assign instr_valid   = !rst && (count_q != '0);
  assign instr_pc      = pc_mem_q[rd_ptr_q];
  assign instr_data    = data_mem_q[rd_ptr_q];

  assign accept = mem_req_valid && mem_req_ready;
  // A response with nothing outstanding belongs to a request issued before reset.
  assign rsp_ok = mem_rsp_valid && (out_q != '0);
  assign push   = rsp_ok && !redirect_valid && (disc_q == '0);
  assign pop    = instr_valid && instr_ready;

  always_comb begin
    count_d    = count_q;
    disc_d     = disc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_q + CW'(accept) - CW'(rsp_ok);
    if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
    if (redirect_valid) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = redirect_pc & ~32'h3;
      rsp_pc_d   = redirect_pc & ~32'h3;
      // Everything still in flight was fetched down the old path.
      disc_d     = out_d;
    end else begin
      if (rsp_ok && (disc_q != '0)) disc_d = disc_q - 1'b1;
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      out_q      <= '0;
      disc_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
    end else begin
      count_q    <= count_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
      data_mem_q[wr_ptr_q] <= mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch_prefetch.sv
// Bench for instr_fetch_prefetch: randomized memory/core behaviour checked against a
// transaction-level model of the fetch stream (expected PCs, buffered count, pending requests).
module tb_instr_fetch_prefetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h100;

  logic        clk = 1'b0;
  logic        rst, redirect_valid, mem_req_ready, mem_rsp_valid, instr_ready;
  logic [31:0] redirect_pc, mem_rsp_data;
  logic        mem_req_valid, instr_valid;
  logic [31:0] mem_req_addr, instr_pc, instr_data;

  instr_fetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_pc       (instr_pc),
    .instr_data     (instr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned ep;
    int unsigned due;
  } req_t;

  req_t        memq[$];
  int unsigned cyc = 0, epoch = 0, last_due = 0;
  int          m_buf = 0;
  logic [31:0] m_fetch = RPC, m_out = RPC;
  int unsigned lat_max = 1, mem_rdy_pct = 100, ird_pct = 100;
  int          errors = 0, checks = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_96E1;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b, want %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: entered right after a falling edge, returns after the next one.
  task automatic step(input logic do_rst, input logic do_redir, input logic [31:0] rpc);
    logic        exp_req, exp_iv, acc, pop, push;
    int unsigned due;
    req_t        r;
    rst            = do_rst;
    redirect_valid = do_redir;
    redirect_pc    = rpc;
    mem_req_ready  = ($urandom % 100) < mem_rdy_pct;
    instr_ready    = ($urandom % 100) < ird_pct;
    if (memq.size() > 0 && memq[0].due == cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = instr_of(memq[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
    end
    #1;
    exp_req = !do_rst && !do_redir && (memq.size() + m_buf < DEPTH);
    exp_iv  = !do_rst && (m_buf != 0);
    chk1("req_valid", mem_req_valid, exp_req);
    if (exp_req || do_rst) chk32("req_addr", mem_req_addr, do_rst ? RPC : m_fetch);
    chk1("instr_valid", instr_valid, exp_iv);
    if (exp_iv) begin
      chk32("instr_pc", instr_pc, m_out);
      chk32("instr_data", instr_data, instr_of(m_out));
    end
    acc = exp_req && mem_req_ready;
    pop = exp_iv && instr_ready;
    @(posedge clk);
    if (do_rst) begin
      memq.delete();
      m_buf    = 0;
      m_fetch  = RPC;
      m_out    = RPC;
      last_due = cyc;
    end else begin
      push = 1'b0;
      if (mem_rsp_valid) begin
        r    = memq.pop_front();
        push = (r.ep == epoch) && !do_redir;
      end
      if (do_redir) begin
        epoch++;
        m_buf   = 0;
        m_fetch = rpc & ~32'h3;
        m_out   = rpc & ~32'h3;
      end else begin
        if (acc) begin
          due = cyc + 1 + ($urandom % lat_max);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          memq.push_back('{addr: m_fetch, ep: epoch, due: due});
          m_fetch = m_fetch + 32'd4;
        end
        m_buf = m_buf + int'(push) - int'(pop);
        if (pop) m_out = m_out + 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; instr_ready = 1'b0;
    @(negedge clk);
    // Reset, single-cycle memory, core always ready
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    run(16);
    // Core stalls: FIFO fills, requests stop, then drain and resume
    ird_pct = 0;
    run(10);
    ird_pct = 100;
    run(10);
    // Slow memory, redirect with requests in flight
    lat_max = 3;
    run(3);
    step(1'b0, 1'b1, 32'h2002);
    run(12);
    // Redirect on a cycle carrying both a response and a pop
    lat_max = 1;
    for (int i = 0; i < 20; i++) begin
      if (memq.size() > 0 && memq[0].due == cyc && m_buf > 0) break;
      run(1);
    end
    step(1'b0, 1'b1, 32'h3000);
    run(8);
    // Address wrap past 2^32
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    run(10);
    // Reset mid-stream with a full FIFO
    ird_pct = 0;
    run(10);
    step(1'b1, 1'b0, 32'h0);
    ird_pct = 100;
    run(8);
    // Randomized traffic with occasional redirects and resets
    for (int i = 0; i < 600; i++) begin
      lat_max     = 1 + ($urandom % 3);
      mem_rdy_pct = 40 + ($urandom % 61);
      ird_pct     = 30 + ($urandom % 71);
      if (($urandom % 100) < 4) begin
        step(1'b0, 1'b1, (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | $urandom % 16) : $urandom);
      end else if (($urandom % 200) == 0) begin
        step(1'b1, 1'b0, 32'h0);
      end else begin
        run(1);
      end
    end
    ird_pct = 100; mem_rdy_pct = 100;
    run(12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
